// File: rtl/seq_op_pkg.sv
// ---------------------------------------------------------------------------
// seq_op_pkg
// Shared constants for the sequential operator-execution stage:
//   - opcode encodings (OP_ADD .. OP_SRA)
//   - FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE)
//   - is_shift_op() helper used by the top-level decode
//
// Flag meaning per opcode:
//   OP_ADD  : carry-out of a + b
//   OP_SUB  : borrow, i.e. a < b as unsigned
//   OP_EQ   : a == b (result is always zero)
//   OP_MAX3 : a strictly greater (signed) than both b and c
//   OP_ORN  : (|a) || !(|b)
//   OP_SHL  : last bit shifted out (0 when the shift amount is 0)
//   OP_SHR  : last bit shifted out (0 when the shift amount is 0)
//   OP_SRA  : last bit shifted out (0 when the shift amount is 0)
// ---------------------------------------------------------------------------
package seq_op_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_EQ   = 3'd2;
    localparam logic [2:0] OP_MAX3 = 3'd3;
    localparam logic [2:0] OP_ORN  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_SHR  = 3'd6;
    localparam logic [2:0] OP_SRA  = 3'd7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // True for the three opcodes handled by the iterative shifter.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        case (op)
            OP_SHL, OP_SHR, OP_SRA: r = 1'b1;
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_op_comb.sv
// ---------------------------------------------------------------------------
// seq_op_comb
// Purely combinational evaluation of the single-cycle opcodes
// (ADD, SUB, EQ, MAX3, ORN). Shift opcodes return zero here; the iterative
// shifter in seq_op_unit handles them.
//
// Ports:
//   op   in  [2:0]   opcode (seq_op_pkg encodings)
//   a    in  [W-1:0] operand A (signed for MAX3)
//   b    in  [W-1:0] operand B
//   c    in  [W-1:0] operand C (MAX3 only)
//   res  out [W-1:0] operation result
//   flg  out         per-op status bit
//
// Build option: SAT_ARITH_EN -- when defined, ADD saturates to all-ones on
// carry and SUB clamps to zero on borrow; the flag still reports
// carry/borrow. When undefined both wrap modulo 2^W.
// ---------------------------------------------------------------------------
module seq_op_comb
    import seq_op_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] res,
    output logic         flg
);

    logic [W:0]   sum_s;
    logic [W:0]   diff_s;
    logic         a_gt_b_s;
    logic         a_gt_c_s;
    logic [W-1:0] max_ab_s;
    logic [W-1:0] max_abc_s;

    // Extra top bit carries the carry-out / borrow.
    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    assign a_gt_b_s  = ($signed(a) > $signed(b));
    assign a_gt_c_s  = ($signed(a) > $signed(c));
    assign max_ab_s  = a_gt_b_s ? a : b;
    assign max_abc_s = ($signed(max_ab_s) > $signed(c)) ? max_ab_s : c;

    // Opcode select for result and flag.
    always_comb begin
        res = {W{1'b0}};
        flg = 1'b0;
        case (op)
            OP_ADD: begin
`ifdef SAT_ARITH_EN
                res = sum_s[W] ? {W{1'b1}} : sum_s[W-1:0];
`else
                res = sum_s[W-1:0];
`endif
                flg = sum_s[W];
            end
            OP_SUB: begin
`ifdef SAT_ARITH_EN
                res = diff_s[W] ? {W{1'b0}} : diff_s[W-1:0];
`else
                res = diff_s[W-1:0];
`endif
                flg = diff_s[W];
            end
            OP_EQ: begin
                res = {W{1'b0}};
                flg = (a == b);
            end
            OP_MAX3: begin
                res = max_abc_s;
                flg = a_gt_b_s && a_gt_c_s;
            end
            OP_ORN: begin
                res = a | ~b;
                flg = (|a) || !(|b);
            end
            default: begin
                res = {W{1'b0}};
                flg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_op_unit.sv
// ---------------------------------------------------------------------------
// seq_op_unit
// Sequential operator-execution stage. Accepts one operation per
// valid/ready request, evaluates it and holds the result on a valid/ready
// output until the consumer takes it. Single-cycle ops are evaluated by
// seq_op_comb; shifts run one bit per cycle in this module.
//
// Ports:
//   clk        in            rising-edge clock
//   rst_n      in            asynchronous active-low reset
//   in_valid   in            request present
//   in_ready   out           unit idle and able to accept
//   op         in  [2:0]     opcode (seq_op_pkg encodings)
//   a, b, c    in  [W-1:0]   operands (a/b/c signed for MAX3, a for SRA)
//   sh         in  [SHW-1:0] shift amount
//   out_valid  out           result present
//   out_ready  in            consumer accepts result
//   result     out [W-1:0]   operation result
//   flag       out           per-op status bit
//
// Build option: SAT_ARITH_EN (see seq_op_comb) selects saturating ADD/SUB.
// ---------------------------------------------------------------------------
module seq_op_unit
    import seq_op_pkg::*;
#(
    parameter int W   = 8,
    parameter int SHW = $clog2(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    input  logic [SHW-1:0] sh,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   result,
    output logic           flag
);

    logic [1:0]     state_q,  state_d;
    logic [W-1:0]   result_q, result_d;
    logic           flag_q,   flag_d;
    logic [W-1:0]   shreg_q,  shreg_d;
    logic [SHW-1:0] cnt_q,    cnt_d;
    logic [2:0]     op_q,     op_d;

    logic [W-1:0]   comb_res_s;
    logic           comb_flg_s;
    logic [W:0]     step_s;

    // One shift step: returns {bit shifted out, shifted value}.
    function automatic logic [W:0] shift_step(input logic [2:0]   kind,
                                              input logic [W-1:0] v);
        logic [W:0] r;
        case (kind)
            OP_SHL:  r = {v[W-1], v[W-2:0], 1'b0};
            OP_SHR:  r = {v[0], 1'b0, v[W-1:1]};
            OP_SRA:  r = {v[0], v[W-1], v[W-1:1]};
            default: r = {1'b0, v};
        endcase
        return r;
    endfunction

    seq_op_comb #(
        .W (W)
    ) u_comb (
        .op  (op),
        .a   (a),
        .b   (b),
        .c   (c),
        .res (comb_res_s),
        .flg (comb_flg_s)
    );

    assign step_s = shift_step(op_q, shreg_q);

    // Both handshake signals are pure state decodes, so out_ready has no
    // combinational path to in_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flag      = flag_q;

    // Next-state and datapath update for accept, shift iteration and drain.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flag_d   = flag_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d = op;
                    if (!is_shift_op(op)) begin
                        state_d  = ST_DONE;
                        result_d = comb_res_s;
                        flag_d   = comb_flg_s;
                    end else if (sh == {SHW{1'b0}}) begin
                        state_d  = ST_DONE;
                        result_d = a;
                        flag_d   = 1'b0;
                    end else begin
                        state_d = ST_SHIFT;
                        shreg_d = a;
                        cnt_d   = sh;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_d = step_s[W-1:0];
                cnt_d   = cnt_q - SHW'(1);
                // Counter reaches zero on this edge: publish the final step.
                if (cnt_q == SHW'(1)) begin
                    state_d  = ST_DONE;
                    result_d = step_s[W-1:0];
                    flag_d   = step_s[W];
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= {W{1'b0}};
            flag_q   <= 1'b0;
            shreg_q  <= {W{1'b0}};
            cnt_q    <= {SHW{1'b0}};
            op_q     <= OP_ADD;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

endmodule

// File: tb/tb_seq_op_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_op_unit
// Directed-vector bench for seq_op_unit (W=8). Expected values are
// hand-computed constants; SAT_ARITH_EN switches the ADD/SUB expectations.
// ---------------------------------------------------------------------------
module tb_seq_op_unit;

    import seq_op_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [2:0] sh;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag;

    int n_vec;
    int n_err;

    int         lat;
    logic [7:0] res_v;
    logic       flg_v;

    seq_op_unit #(
        .W   (8),
        .SHW (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .sh        (sh),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request, scramble the inputs after accept, and wait
    // (bounded) for out_valid. lat counts edges from request to out_valid.
    task automatic run_op(input logic [2:0] o, input logic [7:0] va,
                          input logic [7:0] vb, input logic [7:0] vc,
                          input logic [2:0] vs);
        chk("in_ready_before_req", {31'd0, in_ready}, 32'd1);
        op = o; a = va; b = vb; c = vc; sh = vs;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = ~o; a = ~va; b = ~vb; c = ~vc; sh = ~vs;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res_v = result;
        flg_v = flag;
    endtask

    // Complete the output handshake with out_ready=1 and confirm re-arm.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ov_after_hs"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ir_after_hs"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_op(input string tag, input int exp_lat,
                            input logic [7:0] exp_res, input logic exp_flg);
        chk({tag, "_lat"},  lat, exp_lat);
        chk({tag, "_res"},  {24'd0, res_v}, {24'd0, exp_res});
        chk({tag, "_flag"}, {31'd0, flg_v}, {31'd0, exp_flg});
        drain(tag);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        op = 3'd0; a = 8'd0; b = 8'd0; c = 8'd0; sh = 3'd0;

        #2;
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result",    {24'd0, result},    32'd0);
        chk("rst_flag",      {31'd0, flag},      32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD with carry
        run_op(OP_ADD, 8'hF0, 8'h20, 8'h00, 3'd0);
`ifdef SAT_ARITH_EN
        check_op("add_carry", 1, 8'hFF, 1'b1);
`else
        check_op("add_carry", 1, 8'h10, 1'b1);
`endif
        run_op(OP_ADD, 8'h12, 8'h34, 8'h00, 3'd0);
        check_op("add_nocarry", 1, 8'h46, 1'b0);

        // SUB with and without borrow
        run_op(OP_SUB, 8'h10, 8'h20, 8'h00, 3'd0);
`ifdef SAT_ARITH_EN
        check_op("sub_borrow", 1, 8'h00, 1'b1);
`else
        check_op("sub_borrow", 1, 8'hF0, 1'b1);
`endif
        run_op(OP_SUB, 8'h30, 8'h10, 8'h00, 3'd0);
        check_op("sub_noborrow", 1, 8'h20, 1'b0);

        // Shifts
        run_op(OP_SRA, 8'b10010111, 8'h00, 8'h00, 3'd2);
        check_op("sra2", 3, 8'b11100101, 1'b1);
        run_op(OP_SHL, 8'b10010111, 8'h00, 8'h00, 3'd2);
        check_op("shl2", 3, 8'b01011100, 1'b0);
        run_op(OP_SHR, 8'h80, 8'h00, 8'h00, 3'd7);
        check_op("shr7", 8, 8'h01, 1'b0);
        run_op(OP_SHR, 8'hA5, 8'h00, 8'h00, 3'd0);
        check_op("shr0", 1, 8'hA5, 1'b0);

        // MAX3 / EQ
        run_op(OP_MAX3, 8'd5, 8'd3, 8'hFE, 3'd0);
        check_op("max3_a", 1, 8'd5, 1'b1);
        run_op(OP_MAX3, 8'd3, 8'd3, 8'd1, 3'd0);
        check_op("max3_tie", 1, 8'd3, 1'b0);
        run_op(OP_MAX3, 8'h80, 8'h81, 8'hFF, 3'd0);
        check_op("max3_neg", 1, 8'hFF, 1'b0);
        run_op(OP_EQ, 8'h0D, 8'h0D, 8'h00, 3'd0);
        check_op("eq_true", 1, 8'h00, 1'b1);
        run_op(OP_EQ, 8'h0D, 8'h0C, 8'h00, 3'd0);
        check_op("eq_false", 1, 8'h00, 1'b0);

        // ORN under backpressure
        out_ready = 1'b0;
        run_op(OP_ORN, 8'h0F, 8'hF0, 8'h00, 3'd0);
        chk("orn_lat", lat, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result",    {24'd0, result},    32'h0F);
            chk("bp_flag",      {31'd0, flag},      32'd1);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            @(posedge clk); #1;
        end
        drain("orn_bp");

        // Leave a non-zero result registered before the reset test.
        run_op(OP_SHL, 8'h03, 8'h00, 8'h00, 3'd7);
        check_op("shl7", 8, 8'h80, 1'b1);

        // Reset in the middle of a shift
        op = OP_SHR; a = 8'hFF; sh = 3'd5;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_in_ready_shift", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result",    {24'd0, result},    32'd0);
        chk("mid_rst_flag",      {31'd0, flag},      32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
        end
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(OP_ORN, 8'h00, 8'hFF, 8'h00, 3'd0);
        check_op("orn_zero", 1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_op_unit.md
Name: seq_op_unit

Overview:
Sequential operator-execution stage that sits directly upstream of the result-checking and display logic in the operator test area. It accepts one operation per request over a valid/ready handshake and evaluates it: add/sub with carry, equality, signed max-of-three, bitwise OR-NOT, and logical and arithmetic shifts. Shifts are iterative, one bit per cycle. Each result is held on a valid/ready output until the consumer takes it.

Parameters:
W, 8, operand and result width in bits (W >= 2)
SHW, $clog2(W), width of the shift-amount field

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  unit can accept a request
op  input  3  opcode (encodings in package)
a  input  W  operand A (signed for MAX3 and SRA)
b  input  W  operand B
c  input  W  operand C (MAX3 only)
sh  input  SHW  shift amount (shift ops only)
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
result  output  W  operation result
flag  output  1  per-op status bit

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, result=0, flag=0, internal shift register and counter=0. in_ready is decoded from state, so it is 1 during and after reset.
- Accept: a request is taken on a rising edge where in_valid && in_ready. in_ready = (state==IDLE). The unit holds at most one operation at a time.
- Operands a, b, c, sh and op are captured at accept. Later input changes are ignored.
- Opcodes, with result and flag:
  - ADD=0: result=(a+b) mod 2^W; flag=carry-out.
  - SUB=1: result=(a-b) mod 2^W; flag=borrow (a<b unsigned).
  - EQ=2: result=0; flag=(a==b).
  - MAX3=3: result=signed max(a,b,c); flag=1 only if a is strictly greater than both b and c.
  - ORN=4: result=a | ~b; flag=(|a) || !(|b).
  - SHL=5: logical left shift.
  - SHR=6: logical right shift.
  - SRA=7: arithmetic right shift, sign-replicating.
- Shift flag: the last bit shifted out; 0 when sh==0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> DONE when a non-shift op is accepted. Result is registered; latency is 1 cycle, so out_valid rises on the edge after accept.
  - IDLE -> DONE when a shift op is accepted with sh==0. Result=a, flag=0, latency 1.
  - IDLE -> SHIFT when a shift op is accepted with sh>0. The register is loaded with a and the counter with sh.
  - SHIFT: shift one bit per cycle and decrement the counter. Go to DONE on the edge where the counter reaches 0. Latency is sh+1 cycles from accept to out_valid.
  - DONE: out_valid=1. result and flag stay stable until out_valid && out_ready, then go to IDLE.
- Handshake: out_valid never drops without a handshake. in_ready=0 in SHIFT and DONE. Maximum throughput is one op per 2 cycles.
- No combinational path from out_ready to in_ready.
- Reset mid-operation (SHIFT or DONE): the op is aborted with no output, and all outputs return to reset values.
- in_valid while in_ready=0 has no effect. The requester must hold the request.

Optional Feature:
Macro: SAT_ARITH_EN
- Defined: ADD saturates to all-ones on carry, and SUB clamps to 0 on borrow. flag still reports carry/borrow.
- Undefined: wrap-around modulo 2^W as specified above.

Decomposition:
- Package seq_op_pkg holds:
  - opcode localparams OP_ADD..OP_SRA;
  - FSM state encoding (IDLE, SHIFT, DONE);
  - flag-meaning comments per op.
- One sub-module, seq_op_comb: purely combinational evaluation of the five single-cycle ops (ADD, SUB, EQ, MAX3, ORN), returning result and flag. The shift datapath and FSM stay in seq_op_unit.

Test Plan:
1. ADD a=8'hF0 b=8'h20, out_ready=1 -> out_valid 1 cycle after accept, result=8'h10, flag=1. With SAT_ARITH_EN: result=8'hFF, flag=1.
2. SRA a=8'b10010111 sh=2 -> out_valid 3 cycles after accept, result=8'b11100101, flag=1. SHL same a, sh=2 -> result=8'b01011100, flag=0.
3. MAX3 a=5 b=3 c=8'hFE (-2) -> result=5, flag=1. MAX3 a=3 b=3 c=1 -> result=3, flag=0. EQ a=b=8'h0D -> result=0, flag=1.
4. Backpressure: ORN a=8'h0F b=8'hF0, out_ready held 0 for 4 cycles -> result=8'h0F, flag=1, out_valid=1 and outputs stable throughout, in_ready=0. Raise out_ready -> handshake, in_ready=1 next cycle.
5. Reset mid-op: SHR sh=5 accepted, rst_n pulled low 2 cycles later -> out_valid=0, result=0 immediately; after release in_ready=1 and no stale output appears.
6. Shift sh=0, SHR a=8'hA5 -> result=8'hA5, flag=0, latency 1.
